ingress_port_arbiter: RTL and testbench

Four-port ingress arbiter that feeds the switch core's shared frame FIFO pair. Each port has a per-port data FIFO (8-bit) and descriptor FIFO (16-bit). The block picks ports round-robin and validates each frame descriptor. It then copies valid frames byte-by-byte into the shared data FIFO (`sfifo`) and pushes a 20-bit descriptor into the shared pointer FIFO (`ptr_sfifo`), which the downstream frame processor consumes. Errored and runt frames are drained from the port FIFO and discarded.

---
 rtl/ingress_port_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_ingress_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ingress_port_arbiter.sv
// ingress_port_arbiter
// Four-port round-robin ingress arbiter. Each granted frame descriptor is
// validated; good frames are copied byte-by-byte into the shared data FIFO
// and described in the shared pointer FIFO, while errored and runt frames are
// drained from the port FIFO and discarded.
//
// Optional feature: define INGRESS_DROP_CNT_EN to build the 16-bit saturating
// dropped-frame counter on drop_cnt. Without it drop_cnt is tied to zero.
//
// Handshakes: the port and shared FIFOs have no valid/ready pair. A read
// strobe issued in cycle k returns data during cycle k+1. A write is only
// issued once CHECK has seen enough free space and a non-full pointer FIFO,
// so neither shared FIFO can overflow.
module ingress_port_arbiter #(
    parameter int MIN_LEN = 14
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  port_ptr_empty,
    output logic [3:0]  port_ptr_rd,
    input  logic [63:0] port_ptr_dout,
    output logic [3:0]  port_data_rd,
    input  logic [31:0] port_data_dout,
    output logic        sfifo_wr,
    output logic [7:0]  sfifo_din,
    input  logic [11:0] sfifo_free,
    output logic        ptr_sfifo_wr,
    output logic [19:0] ptr_sfifo_din,
    input  logic        ptr_sfifo_full,
    output logic [15:0] drop_cnt
);

    localparam logic [10:0] MIN_LEN_L = 11'(MIN_LEN);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEL   = 3'd1,
        DESC  = 3'd2,
        CHECK = 3'd3,
        COPY  = 3'd4,
        DROP  = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t      state;
    logic [1:0]  rr;        // round-robin start point for the next grant
    logic [1:0]  g;         // port currently granted
    logic [10:0] len;
    logic [3:0]  pre;
    logic        err;
    logic [10:0] cnt;       // data reads still to issue
    logic [1:0]  tail;      // cycles spent in COPY after the last read
    logic        copy_rd_d1;

    logic [1:0]  gnt_idx;
    logic        gnt_any;
    logic [1:0]  cand;
    logic [15:0] desc_g;
    logic [7:0]  byte_g;
    logic        reject;
    logic        space_ok;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // First non-empty port at or after the round-robin pointer, wrapping 3->0.
    always_comb begin
        gnt_idx = rr;
        gnt_any = 1'b0;
        cand    = rr;
        for (int k = 0; k < 4; k++) begin
            cand = rr + 2'(k);
            if (!gnt_any && !port_ptr_empty[cand]) begin
                gnt_idx = cand;
                gnt_any = 1'b1;
            end
        end
    end

    assign desc_g   = port_ptr_dout[{g, 4'b0000} +: 16];
    assign byte_g   = port_data_dout[{g, 3'b000} +: 8];
    assign reject   = err || (len < MIN_LEN_L);
    assign space_ok = (sfifo_free >= {1'b0, len}) && !ptr_sfifo_full;

    // Frame sequencing: grant, fetch descriptor, validate, then copy or drain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            rr            <= 2'd0;
            g             <= 2'd0;
            len           <= 11'd0;
            pre           <= 4'd0;
            err           <= 1'b0;
            cnt           <= 11'd0;
            tail          <= 2'd0;
            port_ptr_rd   <= 4'd0;
            port_data_rd  <= 4'd0;
            ptr_sfifo_wr  <= 1'b0;
            ptr_sfifo_din <= 20'd0;
        end else begin
            port_ptr_rd  <= 4'd0;
            ptr_sfifo_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        g           <= gnt_idx;
                        port_ptr_rd <= onehot(gnt_idx);
                        state       <= SEL;
                    end
                end
                SEL: begin
                    state <= DESC;
                end
                DESC: begin
                    len   <= desc_g[10:0];
                    pre   <= desc_g[14:11];
                    err   <= desc_g[15];
                    state <= CHECK;
                end
                CHECK: begin
                    if (reject) begin
                        if (len != 11'd0) begin
                            cnt          <= len;
                            port_data_rd <= onehot(g);
                            state        <= DROP;
                        end else begin
                            state <= DONE;
                        end
                    end else if (space_ok) begin
                        cnt          <= len;
                        tail         <= 2'd0;
                        port_data_rd <= (len != 11'd0) ? onehot(g) : 4'd0;
                        state        <= COPY;
                    end
                end
                COPY: begin
                    if (cnt != 11'd0) begin
                        cnt <= cnt - 11'd1;
                        if (cnt == 11'd1) begin
                            port_data_rd <= 4'd0;
                        end
                    end else begin
                        // The last byte leaves the write pipeline one cycle
                        // after the reads stop; the descriptor follows it.
                        tail <= tail + 2'd1;
                        if (tail == 2'd1) begin
                            ptr_sfifo_wr  <= 1'b1;
                            ptr_sfifo_din <= {pre, onehot(g), 1'b0, len};
                        end
                        if (tail == 2'd2) begin
                            state <= DONE;
                        end
                    end
                end
                DROP: begin
                    if (cnt != 11'd0) begin
                        cnt <= cnt - 11'd1;
                        if (cnt == 11'd1) begin
                            port_data_rd <= 4'd0;
                        end
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    rr    <= g + 2'd1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Two-stage copy pipeline: read strobe, then data valid, then write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            copy_rd_d1 <= 1'b0;
            sfifo_wr   <= 1'b0;
            sfifo_din  <= 8'd0;
        end else begin
            copy_rd_d1 <= (state == COPY) && (port_data_rd != 4'd0);
            sfifo_wr   <= copy_rd_d1;
            if (copy_rd_d1) begin
                sfifo_din <= byte_g;
            end
        end
    end

`ifdef INGRESS_DROP_CNT_EN
    logic drop_evt;
    assign drop_evt = ((state == CHECK) && reject && (len == 11'd0)) ||
                      ((state == DROP) && (cnt == 11'd0));

    // Saturating count of discarded frames, including zero-length ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt <= 16'd0;
        end else if (drop_evt && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ingress_port_arbiter.sv
// Testbench for ingress_port_arbiter: port FIFO models, a frame-level
// round-robin reference model, and a scoreboard on the shared FIFO outputs.
module tb_ingress_port_arbiter;

    localparam int MIN_LEN = 14;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  port_ptr_empty = 4'hF;
    logic [3:0]  port_ptr_rd;
    logic [63:0] port_ptr_dout = '0;
    logic [3:0]  port_data_rd;
    logic [31:0] port_data_dout = '0;
    logic        sfifo_wr;
    logic [7:0]  sfifo_din;
    logic [11:0] sfifo_free = 12'd2000;
    logic        ptr_sfifo_wr;
    logic [19:0] ptr_sfifo_din;
    logic        ptr_sfifo_full = 1'b0;
    logic [15:0] drop_cnt;

    ingress_port_arbiter #(.MIN_LEN(MIN_LEN)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .port_ptr_empty (port_ptr_empty),
        .port_ptr_rd    (port_ptr_rd),
        .port_ptr_dout  (port_ptr_dout),
        .port_data_rd   (port_data_rd),
        .port_data_dout (port_data_dout),
        .sfifo_wr       (sfifo_wr),
        .sfifo_din      (sfifo_din),
        .sfifo_free     (sfifo_free),
        .ptr_sfifo_wr   (ptr_sfifo_wr),
        .ptr_sfifo_din  (ptr_sfifo_din),
        .ptr_sfifo_full (ptr_sfifo_full),
        .drop_cnt       (drop_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // port FIFO contents and reference model state
    typedef struct packed {
        logic [10:0] len;
        logic        err;
        logic [3:0]  pre;
    } frame_t;

    logic [7:0]  dq     [4][$];
    logic [15:0] pq     [4][$];
    logic [7:0]  mbytes [4][$];
    frame_t      mq     [4][$];
    logic [7:0]  exp_q  [$];
    logic [19:0] exp_d  [$];
    int          rr_m = 0;
    int          drops_m = 0;

    // Port FIFO model: a read strobe seen in cycle k updates dout in cycle k+1.
    logic [3:0] ptr_prev = '0;
    logic [3:0] data_prev = '0;
    always @(negedge clk) begin
        if (!rstn) begin
            ptr_prev  = '0;
            data_prev = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ptr_prev[i]) begin
                    chk("ptr_fifo_nonempty_on_read", 32'(pq[i].size() != 0), 32'd1);
                    if (pq[i].size() != 0) port_ptr_dout[16*i +: 16] = pq[i].pop_front();
                end
                if (data_prev[i]) begin
                    chk("data_fifo_nonempty_on_read", 32'(dq[i].size() != 0), 32'd1);
                    if (dq[i].size() != 0) port_data_dout[8*i +: 8] = dq[i].pop_front();
                end
            end
            ptr_prev  = port_ptr_rd;
            data_prev = port_data_rd;
        end
        for (int i = 0; i < 4; i++) port_ptr_empty[i] = (pq[i].size() == 0);
    end

    // Output monitor and scoreboard.
    logic [3:0] grant_q     [$];
    int         grant_cyc_q [$];
    int         rd_total = 0;
    int         wr_cnt = 0;
    int         rd_start_cyc = 0;
    int         first_wr_cyc = 0;
    int         ptr_wr_cyc = 0;
    logic [19:0] last_desc = '0;
    bit         rd_prev_mon = 0;
    bit         wr_prev_mon = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            rd_prev_mon = 0;
            wr_prev_mon = 0;
        end else begin
            chk("ptr_rd_onehot", 32'($countones(port_ptr_rd) <= 1), 32'd1);
            chk("data_rd_onehot", 32'($countones(port_data_rd) <= 1), 32'd1);
            if (port_ptr_rd != 4'd0) begin
                grant_q.push_back(port_ptr_rd);
                grant_cyc_q.push_back(cyc);
            end
            if (port_data_rd != 4'd0) begin
                rd_total++;
                if (!rd_prev_mon) rd_start_cyc = cyc;
            end
            rd_prev_mon = (port_data_rd != 4'd0);
            if (sfifo_wr) begin
                wr_cnt++;
                if (!wr_prev_mon) first_wr_cyc = cyc;
                chk("sfifo_byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("sfifo_din", 32'(sfifo_din), 32'(exp_q.pop_front()));
            end
            wr_prev_mon = sfifo_wr;
            if (ptr_sfifo_wr) begin
                last_desc  = ptr_sfifo_din;
                ptr_wr_cyc = cyc;
                chk("ptr_desc_expected", 32'(exp_d.size() != 0), 32'd1);
                if (exp_d.size() != 0) chk("ptr_sfifo_din", 32'(ptr_sfifo_din), 32'(exp_d.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic load_frame(input int p, input int len, input bit err, input logic [3:0] pre);
        frame_t f;
        logic [7:0] b;
        pq[p].push_back({err, pre, 11'(len)});
        f.len = 11'(len);
        f.err = err;
        f.pre = pre;
        mq[p].push_back(f);
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom_range(0, 255));
            dq[p].push_back(b);
            mbytes[p].push_back(b);
        end
    endtask

    // Frame-level reference: round-robin over queued frames, forward or drop.
    task automatic model_run();
        bit any;
        int g;
        frame_t f;
        do begin
            any = 0;
            g = 0;
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (rr_m + k) % 4;
                if (!any && mq[c].size() != 0) begin
                    any = 1;
                    g = c;
                end
            end
            if (any) begin
                f = mq[g].pop_front();
                if (f.err || int'(f.len) < MIN_LEN) begin
                    drops_m++;
                    for (int k = 0; k < int'(f.len); k++) void'(mbytes[g].pop_front());
                end else begin
                    for (int k = 0; k < int'(f.len); k++) exp_q.push_back(mbytes[g].pop_front());
                    exp_d.push_back({f.pre, 4'(1 << g), 1'b0, f.len});
                end
                rr_m = (g + 1) % 4;
            end
        end while (any);
    endtask

    function automatic logic [15:0] exp_drop_cnt();
`ifdef INGRESS_DROP_CNT_EN
        return (drops_m > 65535) ? 16'hFFFF : 16'(drops_m);
`else
        return 16'h0;
`endif
    endfunction

    function automatic bit all_empty();
        bit e;
        e = (exp_q.size() == 0) && (exp_d.size() == 0);
        for (int i = 0; i < 4; i++) e = e && (pq[i].size() == 0) && (dq[i].size() == 0);
        return e;
    endfunction

    task automatic drain(input string tag, input bit rnd);
        bit done;
        int n;
        done = 0;
        n = 0;
        while (n < 20000 && !done) begin
            @(negedge clk); #1;
            if (rnd) begin
                ptr_sfifo_full = ($urandom_range(0, 3) == 0);
                sfifo_free     = 12'($urandom_range(0, 120));
            end
            done = all_empty();
            n++;
        end
        chk({tag, "_drain"}, 32'(done), 32'd1);
        ptr_sfifo_full = 1'b0;
        sfifo_free     = 12'd2000;
        repeat (12) @(negedge clk);
        #1;
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop_cnt()));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_port_ptr_rd"}, 32'(port_ptr_rd), 32'd0);
        chk({tag, "_port_data_rd"}, 32'(port_data_rd), 32'd0);
        chk({tag, "_sfifo_wr"}, 32'(sfifo_wr), 32'd0);
        chk({tag, "_sfifo_din"}, 32'(sfifo_din), 32'd0);
        chk({tag, "_ptr_sfifo_wr"}, 32'(ptr_sfifo_wr), 32'd0);
        chk({tag, "_ptr_sfifo_din"}, 32'(ptr_sfifo_din), 32'd0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
    endtask

    initial begin
        int gb, rb, wb, t_raise, n;

        // reset state
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("idle_no_grant", 32'(grant_q.size()), 32'd0);
        chk("idle_port_ptr_rd", 32'(port_ptr_rd), 32'd0);

        // single frame on port 2, L=64: latency and descriptor
        gb = grant_q.size(); wb = wr_cnt;
        load_frame(2, 64, 1'b0, 4'h0);
        model_run();
        drain("single", 1'b0);
        chk("single_grant", 32'(grant_q[gb]), 32'h4);
        chk("single_bytes", 32'(wr_cnt - wb), 32'd64);
        chk("single_first_wr_latency", 32'(first_wr_cyc - grant_cyc_q[gb]), 32'd5);
        chk("single_ptr_wr_latency", 32'(ptr_wr_cyc - grant_cyc_q[gb]), 32'd69);
        chk("single_desc", 32'(last_desc), 32'h04040);

        // move RR pointer to 1, then load all four ports
        load_frame(0, 20, 1'b0, 4'h3);
        model_run();
        drain("rr_setup", 1'b0);
        gb = grant_q.size();
        for (int p = 0; p < 4; p++) load_frame(p, 60, 1'b0, 4'(p + 5));
        model_run();
        drain("four_port", 1'b0);
        chk("four_grant0", 32'(grant_q[gb]), 32'h2);
        chk("four_grant1", 32'(grant_q[gb + 1]), 32'h4);
        chk("four_grant2", 32'(grant_q[gb + 2]), 32'h8);
        chk("four_grant3", 32'(grant_q[gb + 3]), 32'h1);
        chk("four_spacing", 32'(grant_cyc_q[gb + 1] - grant_cyc_q[gb]), 32'd68);

        // errored frame then good frame on port 0
        gb = grant_q.size(); rb = rd_total; wb = wr_cnt;
        load_frame(0, 100, 1'b1, 4'hA);
        load_frame(0, 60, 1'b0, 4'h9);
        model_run();
        drain("drop", 1'b0);
        chk("drop_reads", 32'(rd_total - rb), 32'd160);
        chk("drop_writes", 32'(wr_cnt - wb), 32'd60);
        chk("drop_spacing", 32'(grant_cyc_q[gb + 1] - grant_cyc_q[gb]), 32'd106);

        // space stall: free=50 for L=60, then free=60
        sfifo_free = 12'd50;
        rb = rd_total;
        load_frame(1, 60, 1'b0, 4'h1);
        model_run();
        repeat (25) @(negedge clk);
        #1;
        chk("stall_space_no_reads", 32'(rd_total - rb), 32'd0);
        sfifo_free = 12'd60;
        t_raise = cyc;
        drain("stall_space", 1'b0);
        chk("stall_space_release", 32'(rd_start_cyc - t_raise), 32'd1);

        // pointer FIFO full stall
        ptr_sfifo_full = 1'b1;
        rb = rd_total;
        load_frame(1, 30, 1'b0, 4'h2);
        model_run();
        repeat (25) @(negedge clk);
        #1;
        chk("stall_full_no_reads", 32'(rd_total - rb), 32'd0);
        ptr_sfifo_full = 1'b0;
        t_raise = cyc;
        drain("stall_full", 1'b0);
        chk("stall_full_release", 32'(rd_start_cyc - t_raise), 32'd1);

        // reset mid-copy at byte 30 of 200 (RR pointer is 2 here)
        wb = wr_cnt;
        load_frame(3, 200, 1'b0, 4'h4);
        model_run();
        n = 0;
        while (n < 2000 && (wr_cnt - wb) < 30) begin
            @(negedge clk); #1;
            n++;
        end
        chk("midcopy_reached_byte30", 32'(wr_cnt - wb), 32'd30);
        rstn = 1'b0;
        #1;
        check_outputs_zero("midcopy_reset");
        for (int i = 0; i < 4; i++) begin
            pq[i].delete(); dq[i].delete(); mq[i].delete(); mbytes[i].delete();
        end
        exp_q.delete();
        exp_d.delete();
        rr_m = 0;
        drops_m = 0;
        repeat (3) @(negedge clk);
        #1;
        rstn = 1'b1;
        gb = grant_q.size();
        load_frame(0, 20, 1'b0, 4'h6);
        load_frame(2, 20, 1'b0, 4'h7);
        model_run();
        drain("post_reset", 1'b0);
        chk("post_reset_first_grant", 32'(grant_q[gb]), 32'h1);
        chk("post_reset_second_grant", 32'(grant_q[gb + 1]), 32'h4);

        // randomized batches with random back-pressure
        for (int b = 0; b < 6; b++) begin
            for (int p = 0; p < 4; p++) begin
                int nf;
                nf = $urandom_range(0, 2);
                for (int f = 0; f < nf; f++) begin
                    int sel, len;
                    sel = $urandom_range(0, 9);
                    if (sel == 0) len = 0;
                    else if (sel <= 2) len = $urandom_range(1, MIN_LEN - 1);
                    else len = $urandom_range(MIN_LEN, 60);
                    load_frame(p, len, ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
                end
            end
            model_run();
            drain("random", 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
